// File: rtl/psum_seq_ctrl_pkg.sv
// Shared accelerator definitions for the partial-sum sequencing controller.
// Holds the controller state encoding and the default tile-count width.
package psum_seq_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUTPUT = 3'd4
    } psum_state_e;

endpackage

// File: rtl/psum_seq_ctrl.sv
// Sequences one partial-sum accumulation job: clear, accumulate N tiles,
// drain the final addition, then hold the result until downstream takes it.
module psum_seq_ctrl
    import psum_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LANES = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_tiles,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tile_cnt
);

    // LANES only describes the attached accumulator; reject a degenerate one.
    if (LANES == 0) begin : g_lanes_chk
        $error("psum_seq_ctrl: LANES must be nonzero");
    end

    psum_state_e      r_state;
    psum_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] w_num_nxt;
    logic [CNT_W-1:0] r_tile_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_in_ready;
    logic             w_acc_clr;
    logic             w_out_valid;
    logic             w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_num      <= '0;
            r_tile_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_num      <= w_num_nxt;
            r_tile_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_tile_cnt;
        w_in_ready  = 1'b0;
        w_acc_clr   = 1'b0;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Count is held for inspection until the next job is accepted.
                if (start) begin
                    w_num_nxt   = num_tiles;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_acc_clr   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = (r_num != '0) ? ST_ACCUM : ST_OUTPUT;
            end
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_cnt_nxt = r_tile_cnt + CNT_W'(1);
                    if (r_tile_cnt == r_num - CNT_W'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign acc_clr   = w_acc_clr;
    assign acc_en    = in_valid & w_in_ready;
    assign out_valid = w_out_valid;
    assign done      = w_done;
    assign busy      = (r_state != ST_IDLE);
    assign tile_cnt  = r_tile_cnt;

endmodule
